// File: rtl/irq_timer_pkg.sv
// Shared register map, bit positions and NMI generator states for irq_timer.
package irq_timer_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_RELOAD_LO = 3'd2;
  localparam logic [2:0] REG_RELOAD_HI = 3'd3;
  localparam logic [2:0] REG_COUNT_LO  = 3'd4;
  localparam logic [2:0] REG_COUNT_HI  = 3'd5;
  localparam logic [2:0] REG_SOFT      = 3'd6;
  localparam logic [2:0] REG_NMI_DELAY = 3'd7;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IEN     = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_RELOAD  = 7;

  localparam int unsigned ST_TPEND = 0;
  localparam int unsigned ST_SPEND = 1;
  localparam int unsigned ST_NPEND = 2;

  localparam int unsigned SOFT_SET = 0;
  localparam int unsigned SOFT_NMI = 1;

  typedef enum logic [1:0] {
    NMI_IDLE,
    NMI_ARMED,
    NMI_FIRE
  } nmi_state_t;

endpackage

// File: rtl/irq_down_counter.sv
// Loadable down-counter that holds at zero; load has priority over tick.
module irq_down_counter #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/irq_timer.sv
// Bus-mapped interrupt source: 16-bit reload timer, software IRQ latch and
// delayed NMI generator, all advancing only on cs/phi3-qualified clocks.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [15:0] RESET_RELOAD    = 16'hFFFF,
  parameter logic [7:0]  NMI_DELAY_RESET = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi3,
  input  logic       cs,
  input  logic [2:0] addr,
  input  logic       write,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq,
  output logic       nmi
);

  logic        ctrl_en, ctrl_ien, ctrl_oneshot;
  logic        tpend, spend, npend;
  logic [15:0] reload_q;
  logic [7:0]  nmi_delay_q, snap_q;
  logic [15:0] count;
  logic        count_zero;
  logic [7:0]  nmi_cnt;
  logic        nmi_zero;
  nmi_state_t  nmi_state, nmi_next;
  logic        npend_set, nmi_tick;
  logic [7:0]  rd_data;

  logic bus_wr, bus_rd;
  assign bus_wr = cs & phi3 & write;
  assign bus_rd = cs & phi3 & ~write;

  logic wr_ctrl, wr_status, wr_lo, wr_hi, wr_soft, wr_delay;
  assign wr_ctrl   = bus_wr && (addr == REG_CTRL);
  assign wr_status = bus_wr && (addr == REG_STATUS);
  assign wr_lo     = bus_wr && (addr == REG_RELOAD_LO);
  assign wr_hi     = bus_wr && (addr == REG_RELOAD_HI);
  assign wr_soft   = bus_wr && (addr == REG_SOFT);
  assign wr_delay  = bus_wr && (addr == REG_NMI_DELAY);

  // A reload strobe suppresses the tick entirely, so no expiry can coincide with it.
  logic reload_strobe, tick, expire, hi_load, timer_load;
  logic [15:0] timer_load_val;
  assign reload_strobe  = wr_ctrl & data_i[CTRL_RELOAD];
  assign tick           = phi3 & ctrl_en & ~reload_strobe;
  assign expire         = tick & count_zero;
  assign hi_load        = wr_hi & ~ctrl_en;
  assign timer_load     = reload_strobe | expire | hi_load;
  assign timer_load_val = hi_load ? {data_i, reload_q[7:0]} : reload_q;

  irq_down_counter #(
    .WIDTH     (16),
    .RESET_VAL (RESET_RELOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (tick),
    .count    (count),
    .zero     (count_zero)
  );

  logic arm;
  assign arm = wr_soft & data_i[SOFT_NMI];

  irq_down_counter #(
    .WIDTH     (8),
    .RESET_VAL (8'd0)
  ) u_nmi_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (arm),
    .load_val (nmi_delay_q),
    .tick     (nmi_tick),
    .count    (nmi_cnt),
    .zero     (nmi_zero)
  );

  // Fires on the phi3 that takes the count to zero (or immediately when already zero).
  always_comb begin
    nmi_next  = nmi_state;
    npend_set = 1'b0;
    nmi_tick  = 1'b0;
    if (arm) begin
      nmi_next = NMI_ARMED;
    end else begin
      case (nmi_state)
        NMI_ARMED: if (phi3) begin
          nmi_tick = 1'b1;
          if (nmi_zero || nmi_cnt == 8'd1) begin
            npend_set = 1'b1;
            nmi_next  = NMI_FIRE;
          end
        end
        NMI_FIRE: if (phi3) nmi_next = NMI_IDLE;
        default:  nmi_next = NMI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) nmi_state <= NMI_IDLE;
    else       nmi_state <= nmi_next;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_CTRL:      rd_data = {5'b0, ctrl_oneshot, ctrl_ien, ctrl_en};
      REG_STATUS:    rd_data = {5'b0, npend, spend, tpend};
      REG_RELOAD_LO: rd_data = reload_q[7:0];
      REG_RELOAD_HI: rd_data = reload_q[15:8];
      REG_COUNT_LO:  rd_data = count[7:0];
      REG_COUNT_HI:  rd_data = snap_q;
      REG_NMI_DELAY: rd_data = nmi_delay_q;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_ien     <= 1'b0;
      ctrl_oneshot <= 1'b0;
      tpend        <= 1'b0;
      spend        <= 1'b0;
      npend        <= 1'b0;
      reload_q     <= RESET_RELOAD;
      nmi_delay_q  <= NMI_DELAY_RESET;
      snap_q       <= '0;
      data_o       <= '0;
      irq          <= 1'b0;
      nmi          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= data_i[CTRL_EN];
        ctrl_ien     <= data_i[CTRL_IEN];
        ctrl_oneshot <= data_i[CTRL_ONESHOT];
      end else if (expire && ctrl_oneshot) begin
        ctrl_en <= 1'b0;
      end
      tpend <= expire | (tpend & ~(wr_status & data_i[ST_TPEND]));
      spend <= (wr_soft & data_i[SOFT_SET]) | (spend & ~(wr_status & data_i[ST_SPEND]));
      npend <= npend_set | (npend & ~(wr_status & data_i[ST_NPEND]));
      if (wr_lo)    reload_q[7:0]  <= data_i;
      if (wr_hi)    reload_q[15:8] <= data_i;
      if (wr_delay) nmi_delay_q    <= data_i;
      if (bus_rd) begin
        data_o <= rd_data;
        if (addr == REG_COUNT_LO) snap_q <= count[15:8];
      end
      irq <= (tpend & ctrl_ien) | spend;
      nmi <= npend;
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// Directed table-driven bench for irq_timer plus hand-written corner sequences.
module tb_irq_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phi3 = 1'b0;
  logic       cs = 1'b0;
  logic [2:0] addr = '0;
  logic       write = 1'b0;
  logic [7:0] data_i = '0;
  logic [7:0] data_o;
  logic       irq, nmi;

  int total = 0;
  int bad = 0;

  irq_timer #(
    .RESET_RELOAD    (16'hFFFF),
    .NMI_DELAY_RESET (8'd2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .phi3   (phi3),
    .cs     (cs),
    .addr   (addr),
    .write  (write),
    .data_i (data_i),
    .data_o (data_o),
    .irq    (irq),
    .nmi    (nmi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       wr;
    logic [2:0] a;
    logic [7:0] d;
    logic       rd_chk;
    logic [7:0] exp_d;
    logic       exp_irq;
    logic       exp_nmi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vw(input logic [2:0] a, input logic [7:0] d,
                              input logic ei, input logic en);
    vec_t v;
    v = '{1'b1, 1'b1, a, d, 1'b0, 8'h00, ei, en};
    return v;
  endfunction

  function automatic vec_t vr(input logic [2:0] a, input logic [7:0] e,
                              input logic ei, input logic en);
    vec_t v;
    v = '{1'b1, 1'b0, a, 8'h00, 1'b1, e, ei, en};
    return v;
  endfunction

  function automatic vec_t vi(input logic ei, input logic en);
    vec_t v;
    v = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, ei, en};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic p, input logic c, input logic w,
                       input logic [2:0] a, input logic [7:0] d);
    phi3 = p; cs = c; write = w; addr = a; data_i = d;
    @(posedge clk);
    #1;
    phi3 = 1'b0; cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    cycle(1'b1, 1'b1, 1'b0, a, 8'h00);
    d = data_o;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] lo, hi, rv;

    // Reset state
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    check("reset data_o", 16'(data_o), 16'h00);
    check("reset irq", 16'(irq), 16'h0);
    check("reset nmi", 16'(nmi), 16'h0);

    // Reset reads of all eight addresses
    tbl.push_back(vr(3'd0, 8'h00, 0, 0));
    tbl.push_back(vr(3'd1, 8'h00, 0, 0));
    tbl.push_back(vr(3'd2, 8'hFF, 0, 0));
    tbl.push_back(vr(3'd3, 8'hFF, 0, 0));
    tbl.push_back(vr(3'd4, 8'hFF, 0, 0));
    tbl.push_back(vr(3'd5, 8'hFF, 0, 0));
    tbl.push_back(vr(3'd6, 8'h00, 0, 0));
    tbl.push_back(vr(3'd7, 8'h02, 0, 0));
    // Continuous timer, period 4 ticks
    tbl.push_back(vw(3'd2, 8'h03, 0, 0));
    tbl.push_back(vw(3'd3, 8'h00, 0, 0));
    tbl.push_back(vw(3'd0, 8'h80, 0, 0));
    tbl.push_back(vw(3'd0, 8'h03, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(1, 0));
    tbl.push_back(vw(3'd1, 8'h01, 1, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vr(3'd1, 8'h01, 1, 0));
    // Set wins over clear on expiry clock
    tbl.push_back(vw(3'd1, 8'h01, 1, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vw(3'd1, 8'h01, 0, 0));
    tbl.push_back(vr(3'd1, 8'h01, 1, 0));
    tbl.push_back(vw(3'd0, 8'h00, 1, 0));
    tbl.push_back(vw(3'd1, 8'h01, 0, 0));
    // Software IRQ with IEN=0
    tbl.push_back(vw(3'd6, 8'h01, 0, 0));
    tbl.push_back(vr(3'd1, 8'h02, 1, 0));
    tbl.push_back(vw(3'd1, 8'h02, 1, 0));
    tbl.push_back(vi(0, 0));
    // One-shot
    tbl.push_back(vw(3'd2, 8'h01, 0, 0));
    tbl.push_back(vw(3'd3, 8'h00, 0, 0));
    tbl.push_back(vw(3'd0, 8'h87, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(1, 0));
    tbl.push_back(vi(1, 0));
    tbl.push_back(vr(3'd0, 8'h06, 1, 0));
    tbl.push_back(vr(3'd4, 8'h01, 1, 0));
    tbl.push_back(vr(3'd5, 8'h00, 1, 0));
    tbl.push_back(vr(3'd1, 8'h01, 1, 0));
    tbl.push_back(vw(3'd1, 8'h01, 1, 0));
    tbl.push_back(vr(3'd1, 8'h00, 0, 0));
    // Delayed NMI, delay 3
    tbl.push_back(vw(3'd7, 8'h03, 0, 0));
    tbl.push_back(vw(3'd6, 8'h02, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 1));
    tbl.push_back(vr(3'd1, 8'h04, 0, 1));
    tbl.push_back(vw(3'd1, 8'h00, 0, 1));
    tbl.push_back(vr(3'd7, 8'h03, 0, 1));
    tbl.push_back(vw(3'd1, 8'h04, 0, 1));
    tbl.push_back(vi(0, 0));
    // Delay 0 fires on the next phi3
    tbl.push_back(vw(3'd7, 8'h00, 0, 0));
    tbl.push_back(vw(3'd6, 8'h02, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 1));
    tbl.push_back(vw(3'd1, 8'h04, 0, 1));
    tbl.push_back(vi(0, 0));
    // Re-arm restarts the countdown
    tbl.push_back(vw(3'd7, 8'h03, 0, 0));
    tbl.push_back(vw(3'd6, 8'h02, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vw(3'd6, 8'h02, 0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 0));
    tbl.push_back(vi(0, 1));
    tbl.push_back(vw(3'd1, 8'h04, 0, 1));
    tbl.push_back(vi(0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(1'b1, tbl[i].cs, tbl[i].wr, tbl[i].a, tbl[i].d);
      if (tbl[i].rd_chk)
        check($sformatf("row%0d data", i), 16'(data_o), 16'(tbl[i].exp_d));
      check($sformatf("row%0d irq", i), 16'(irq), 16'(tbl[i].exp_irq));
      check($sformatf("row%0d nmi", i), 16'(nmi), 16'(tbl[i].exp_nmi));
    end

    // Tick and RELOAD_HI write on one clock with EN=1: the tick wins
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    bus_wr(3'd0, 8'h01);
    idle(1);
    bus_wr(3'd3, 8'h00);
    bus_rd(3'd4, lo);
    bus_rd(3'd5, hi);
    check("tick_vs_hi count", {hi, lo}, 16'hFFFD);
    bus_rd(3'd3, rv);
    check("tick_vs_hi reload_hi", 16'(rv), 16'h00);

    // phi3 stall freezes the timer and ignores bus writes
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd2, 8'h34);
    bus_wr(3'd3, 8'h12);
    bus_wr(3'd0, 8'h01);
    idle(4);
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 3'd3, 8'hAA);
    bus_rd(3'd4, lo);
    bus_rd(3'd5, hi);
    check("stall count_lo", 16'(lo), 16'h30);
    check("stall count_hi", 16'(hi), 16'h12);
    check("stall count16", {hi, lo}, 16'h1230);
    idle(3);
    check("data_o hold", 16'(data_o), 16'h12);
    bus_wr(3'd0, 8'h00);
    bus_rd(3'd3, rv);
    check("stall reload_hi", 16'(rv), 16'h12);

    // Reset in the middle of an NMI countdown
    bus_wr(3'd7, 8'h05);
    bus_wr(3'd6, 8'h02);
    idle(2);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    idle(8);
    check("abort nmi", 16'(nmi), 16'h0);
    bus_rd(3'd1, rv);
    check("abort status", 16'(rv), 16'h00);
    bus_rd(3'd7, rv);
    check("abort nmi_delay", 16'(rv), 16'h02);
    bus_rd(3'd0, rv);
    check("abort ctrl", 16'(rv), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped interrupt source that responds to `cpu4510` bus cycles and drives the CPU's `irq` and `nmi` inputs. Contains a 16-bit reload timer, a software IRQ latch, and a delayed NMI generator. Replaces the ad-hoc `io_port` logic in simulation and is the synthesizable peripheral on the I/O bus, decoded alongside `hyper_ctrl`.

## Interface
- `RESET_RELOAD`, default 16'hFFFF: reset value of the reload and count registers.
- `NMI_DELAY_RESET`, default 8'd2: reset value of the NMI delay register.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `phi3`  in  1  bus strobe; one CPU cycle per `phi3` high clock (includes `ready`).
- `cs`  in  1  chip select from the address decoder.
- `addr`  in  3  register index (`cpu_address[2:0]`).
- `write`  in  1  CPU write (`write_out`).
- `data_i`  in  8  CPU write data.
- `data_o`  out  8  registered read data.
- `irq`  out  1  level IRQ to CPU, active-high.
- `nmi`  out  1  level NMI to CPU, active-high.

## Operation
- Registers are committed or read only on clocks where `cs & phi3`.
- Register map:
  - 0 CTRL (rw): bit0 EN, bit1 IEN, bit2 ONESHOT, bit7 RELOAD (write-only strobe, reads 0).
  - 1 STATUS: read bit0 TPEND, bit1 SPEND, bit2 NPEND. Writing 1 clears a bit; writing 0 leaves it.
  - 2/3 RELOAD_LO/HI (rw). Writing HI while EN=0 also loads COUNT.
  - 4 COUNT_LO: read returns live low byte and snapshots the high byte.
  - 5 COUNT_HI: read returns the snapshot.
  - 6 SOFT (write-only, reads 0): bit0 sets SPEND; bit1 arms NMI countdown.
  - 7 NMI_DELAY (rw).
- Timer ticks on every `phi3` clock with EN=1:
  - COUNT != 0: decrement.
  - COUNT == 0: set TPEND, load RELOAD; if ONESHOT, clear EN.
- A CTRL write with RELOAD=1 loads COUNT from RELOAD on that clock. This overrides the tick.
- NMI generator has states IDLE, ARMED, FIRE.
  - SOFT bit1 write: load NMI_DELAY into the down-counter and go to ARMED.
  - ARMED: decrement on each `phi3`. When it reaches 0, set NPEND and return to IDLE.
  - A delay value of 0 sets NPEND on the next `phi3`.
  - Re-arming while ARMED restarts the countdown.
- `irq = (TPEND & IEN) | SPEND`, registered.
- `nmi = NPEND`, registered. The CPU edge-detects NMI; software clears NPEND.
- Out-of-range or unused bits read 0.

## Timing
- Reset values:
  - outputs: `data_o`=0, `irq`=0, `nmi`=0.
  - registers: CTRL=0, STATUS=0, RELOAD=COUNT=`RESET_RELOAD`, NMI_DELAY=`NMI_DELAY_RESET`, snapshot=0, NMI FSM IDLE.
- Reset mid-countdown aborts the countdown with no pending bit set.
- Read: `data_o` is registered on the `cs & phi3 & ~write` clock and is valid from the next clock. It holds until the next read.
- Write: the register takes the new value at the `cs & phi3 & write` clock edge.
- Interrupts: `irq`/`nmi` reflect pending-bit changes one clock after the bit changes.
- Simultaneous events:
  - Hardware set and software clear of the same STATUS bit on one clock: set wins.
  - Tick and RELOAD_HI write on one clock with EN=1: COUNT follows the tick, not the write.
  - Write of CTRL with EN=1 and RELOAD=1: COUNT loads; decrementing begins on the following tick.
- Without `phi3`, no state changes; `ready`=0 freezes the timer.

## Structure
- Package `irq_timer_pkg`:
  - register index localparams REG_CTRL..REG_NMI_DELAY.
  - CTRL/STATUS bit positions.
  - NMI FSM state enum.
- Sub-module `irq_down_counter`: parameterized width, ports `load`, `load_val`, `tick`, `zero`. Instantiated for the 16-bit timer and the 8-bit NMI delay.

## Test plan
- Reset: assert `reset` for 4 clocks. Read all 8 addresses → CTRL=00, STATUS=00, RELOAD=FF/FF, NMI_DELAY=02, `irq`=`nmi`=0.
- Continuous timer:
  - Stimulus: RELOAD=0x0003, CTRL RELOAD strobe, then CTRL=0x03.
  - Response: TPEND and `irq` assert after 4 `phi3` ticks and again every 4 ticks.
  - Writing STATUS=01 drops `irq` one clock later.
- One-shot:
  - Stimulus: RELOAD=0x0001, CTRL=0x87.
  - Response: single TPEND after 2 ticks; CTRL reads 0x06; COUNT stays 0x0001.
- Delayed NMI: NMI_DELAY=3, SOFT=0x02 → `nmi` rises after exactly 3 `phi3` cycles. It stays high until STATUS=04 is written.
- Software IRQ and set-wins:
  - SOFT=0x01 → `irq`=1 with IEN=0.
  - Tick to zero on the same clock as STATUS=01 write → TPEND reads 1.
- `ready` stall: hold `phi3` low for 10 clocks mid-count → COUNT is unchanged. COUNT_LO then COUNT_HI return a consistent 16-bit value.
